// File: rtl/pulse_spacer_pkg.sv
// -----------------------------------------------------------------------------
// pulse_spacer_pkg
//   Shared definitions for the pulse_spacer fast-domain front end:
//     state_e    - FSM state encoding (IDLE / PULSE / GAP)
//     gap_cnt_w  - width of the gap counter for a given GAP_CYCLES
// -----------------------------------------------------------------------------
package pulse_spacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // The gap counter is loaded with GAP_CYCLES-1; one spare bit keeps the
  // width legal and comfortable for GAP_CYCLES == 1.
  function automatic int gap_cnt_w(input int gap_cycles);
    return $clog2(gap_cycles) + 1;
  endfunction

endpackage : pulse_spacer_pkg

// File: rtl/pulse_spacer.sv
// -----------------------------------------------------------------------------
// pulse_spacer
//   Fast-domain front end for the fast-to-slow single-bit pulse synchronizer.
//   Single-cycle events on clk_fast are queued in a saturating pending counter
//   and re-emitted as single-cycle pulses at least GAP_CYCLES+1 cycles apart,
//   so the synchronizer's toggle/feedback loop is idle before each new pulse.
//
// Parameters
//   GAP_CYCLES  idle cycles forced after each issued pulse (>= 1); must exceed
//               the synchronizer round trip (>= 3 clk_slow + 2 clk_fast)
//   CNT_W       pending counter width; up to 2^CNT_W-1 events held
//
// Ports
//   clk_fast   in   fast clock, all logic on posedge
//   rstn       in   asynchronous active-low reset
//   clr        in   synchronous clear of queue, flag and FSM (highest priority)
//   event_in   in   each cycle sampled high counts as one event
//   pulse_out  out  single-cycle spaced pulse towards synchronizer data_in
//   busy       out  high while the FSM is not IDLE
//   pending    out  events accepted but not yet issued
//   overflow   out  sticky; set when an event had to be dropped
// -----------------------------------------------------------------------------
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int GAP_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic             clr,
  input  logic             event_in,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int             GW       = gap_cnt_w(GAP_CYCLES);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q,   gap_d;
  logic [CNT_W-1:0] pend_q,  pend_d;
  logic             ovf_q,   ovf_d;
  logic             pulse_q, busy_q;
  logic             want;
  logic             consume;

  // Something to issue: either a fresh event this cycle or a queued one.
  assign want = event_in || (pend_q != '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    consume = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (want) begin
          state_d = ST_PULSE;
          consume = 1'b1;
        end
      end
      ST_PULSE: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          // Back-to-back issue straight out of GAP keeps spacing at exactly
          // GAP_CYCLES+1 while the queue is non-empty.
          if (want) begin
            state_d = ST_PULSE;
            consume = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending bookkeeping. On a consume with an empty queue the consumed
    // event is this cycle's event_in, so the count does not move; with a
    // non-empty queue the count moves by inc-1.
    if (consume) begin
      if (pend_q != '0 && !event_in) begin
        pend_d = pend_q - CNT_W'(1);
      end
    end else if (event_in) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;  // event dropped, count stays at max
      end else begin
        pend_d = pend_q + CNT_W'(1);
      end
    end

    // Clear wins over everything, including this cycle's event.
    if (clr) begin
      state_d = ST_IDLE;
      gap_d   = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      // Outputs come straight from flops so the synchronizer input is
      // glitch-free and exactly one cycle wide.
      pulse_q <= (state_d == ST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule : pulse_spacer

// File: tb/tb_pulse_spacer.sv
// -----------------------------------------------------------------------------
// tb_pulse_spacer
//   Self-checking bench for pulse_spacer with GAP_CYCLES=4, CNT_W=3.
//   A cycle model predicts pulse_out/busy/pending/overflow for every edge; the
//   prediction is queued when stimulus is applied and popped for comparison
//   after the edge. Directed checks cover the listed scenarios on top.
// -----------------------------------------------------------------------------
module tb_pulse_spacer;

  localparam int GAP  = 4;
  localparam int CW   = 3;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk_fast = 1'b0;
  logic          rstn;
  logic          clr;
  logic          event_in;
  logic          pulse_out;
  logic          busy;
  logic [CW-1:0] pending;
  logic          overflow;

  pulse_spacer #(
    .GAP_CYCLES (GAP),
    .CNT_W      (CW)
  ) dut (
    .clk_fast  (clk_fast),
    .rstn      (rstn),
    .clr       (clr),
    .event_in  (event_in),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk_fast = ~clk_fast;

  typedef struct packed {
    logic        pulse;
    logic        busy;
    logic [31:0] pend;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   rises[$];
  int   n_checks;
  int   n_err;
  int   edge_n;
  int   last_issue;
  int   m_pend;
  int   m_issued;
  bit   m_ovf;
  int   dut_pulses;
  int   peak_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_issue = -1000;
    m_pend     = 0;
    m_ovf      = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, queue the
  // prediction, then sample the DUT 1 time unit later and compare.
  // The model treats spacing as "edges since the last issue" rather than
  // as an explicit state machine.
  task automatic step(input logic ev, input logic cl);
    exp_t e;
    event_in = ev;
    clr      = cl;
    @(posedge clk_fast);
    if (!rstn || cl) begin
      model_reset();
    end else if ((edge_n - last_issue >= GAP + 1) && (ev || m_pend != 0)) begin
      last_issue = edge_n;
      m_issued++;
      if (m_pend != 0) m_pend = m_pend + int'(ev) - 1;
    end else if (ev) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else                m_pend++;
    end
    e.pulse = (last_issue == edge_n);
    e.busy  = (edge_n - last_issue <= GAP);
    e.pend  = m_pend;
    e.ovf   = m_ovf;
    sb.push_back(e);
    edge_n++;
    #1;
    e = sb.pop_front();
    check("sb_pulse_out", {31'd0, pulse_out}, {31'd0, e.pulse});
    check("sb_busy",      {31'd0, busy},      {31'd0, e.busy});
    check("sb_pending",   {29'd0, pending},   e.pend);
    check("sb_overflow",  {31'd0, overflow},  {31'd0, e.ovf});
    if (pulse_out === 1'b1) begin
      rises.push_back(edge_n);
      dut_pulses++;
    end
    if (int'(pending) > peak_pend) peak_pend = int'(pending);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((busy !== 1'b0 || pending !== '0) && n < max_cycles) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("drain_bound", {31'd0, (n < max_cycles)}, 32'd1);
  endtask

  initial begin
    int start_issued;
    int d0;
    int busy_cnt;

    // NOTE: stimulus is driven with blocking assignments away from the
    // active edge so the DUT samples settled values.
    rstn       = 1'b0;
    clr        = 1'b0;
    event_in   = 1'b0;
    n_checks   = 0;
    n_err      = 0;
    edge_n     = 0;
    m_issued   = 0;
    dut_pulses = 0;
    peak_pend  = 0;
    model_reset();

    #12;
    check("rst_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_pending",   {29'd0, pending},   32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    rstn = 1'b1;

    // 1: single event -> one pulse next cycle, busy for GAP+1 cycles.
    repeat (9) step(1'b0, 1'b0);
    d0 = dut_pulses;
    step(1'b1, 1'b0);
    check("t1_pulse", {31'd0, pulse_out}, 32'd1);
    check("t1_pend",  {29'd0, pending},   32'd0);
    busy_cnt = 1;
    repeat (6) begin
      step(1'b0, 1'b0);
      if (busy === 1'b1) busy_cnt++;
    end
    check("t1_busy_len",   busy_cnt,         GAP + 1);
    check("t1_pulse_cnt",  dut_pulses - d0,  32'd1);

    // 2: three back-to-back events -> pulses GAP+1 apart.
    rises.delete();
    step(1'b1, 1'b0);
    check("t2_pend0", {29'd0, pending}, 32'd0);
    step(1'b1, 1'b0);
    check("t2_pend1", {29'd0, pending}, 32'd1);
    step(1'b1, 1'b0);
    check("t2_pend2", {29'd0, pending}, 32'd2);
    drain(40);
    check("t2_npulses", rises.size(), 32'd3);
    if (rises.size() == 3) begin
      check("t2_space_a", rises[1] - rises[0], GAP + 1);
      check("t2_space_b", rises[2] - rises[1], GAP + 1);
    end
    check("t2_ovf", {31'd0, overflow}, 32'd0);

    // 3: event held for 12 cycles -> saturation and sticky overflow.
    rises.delete();
    start_issued = m_issued;
    peak_pend    = 0;
    repeat (12) step(1'b1, 1'b0);
    check("t3_ovf_set",  {31'd0, overflow}, 32'd1);
    check("t3_pend_max", {29'd0, pending},  PMAX);
    drain(200);
    check("t3_npulses",  rises.size(), m_issued - start_issued);
    check("t3_npulses_abs", rises.size(), 32'd10);
    for (int i = 1; i < rises.size(); i++)
      check("t3_spacing", rises[i] - rises[i-1], GAP + 1);
    check("t3_peak",     peak_pend, PMAX);
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 4: event on the last GAP cycle -> immediate re-issue, no IDLE cycle.
    step(1'b1, 1'b0);
    repeat (GAP) step(1'b0, 1'b0);
    check("t4_busy_last_gap", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0);
    check("t4_pulse", {31'd0, pulse_out}, 32'd1);
    drain(40);

    // 5: clr mid-GAP with pending=5, event_in=1, overflow still set.
    repeat (7) step(1'b1, 1'b0);
    check("t5_pre_pend",  {29'd0, pending},   32'd5);
    check("t5_pre_busy",  {31'd0, busy},      32'd1);
    check("t5_pre_pulse", {31'd0, pulse_out}, 32'd0);
    check("t5_pre_ovf",   {31'd0, overflow},  32'd1);
    step(1'b1, 1'b1);
    check("t5_pend",  {29'd0, pending},   32'd0);
    check("t5_ovf",   {31'd0, overflow},  32'd0);
    check("t5_busy",  {31'd0, busy},      32'd0);
    check("t5_pulse", {31'd0, pulse_out}, 32'd0);
    d0 = dut_pulses;
    repeat (20) step(1'b0, 1'b0);
    check("t5_no_pulse", dut_pulses - d0, 32'd0);

    // 6: async reset between edges while in PULSE.
    step(1'b1, 1'b0);
    check("t6_in_pulse", {31'd0, pulse_out}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("t6_async_pulse", {31'd0, pulse_out}, 32'd0);
    check("t6_async_busy",  {31'd0, busy},      32'd0);
    check("t6_async_pend",  {29'd0, pending},   32'd0);
    repeat (2) step(1'b0, 1'b0);
    #2;
    rstn = 1'b1;
    d0 = dut_pulses;
    repeat (50) step(1'b0, 1'b0);
    check("t6_no_pulse", dut_pulses - d0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pulse_spacer
